sub_bytes_lanes: RTL
====================

# sub_bytes_lanes

Iterative AES byte-substitution engine that replaces the single-cycle, forward-only 128-bit substitution stage. Each cycle it runs `LANES` S-box lookups over the 16-byte state, in either forward (SubBytes) or inverse (InvSubBytes) mode. It uses valid/ready handshakes on both sides. It sits between the round-key adder and the row-shift stage of the cipher datapath, and lets area-constrained builds trade latency for fewer S-box instances.

## Interface
- `LANES`, default 4: S-box lookups per cycle; legal values 1, 2, 4, 8, 16. Any other value is a elaboration error.
- `i_clock`  in  1  rising-edge clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_data`  in  [0:127]  input state; byte k = bits [8k:8k+7]; byte 0 = bits [0:7].
- `i_inverse`  in  1  0 = forward S-box, 1 = inverse S-box. Sampled on accept.
- `i_valid`  in  1  upstream presents `i_data`/`i_inverse`.
- `o_ready`  out  1  block can accept this cycle.
- `o_data`  out  [0:127]  substituted state; meaningful only while `o_valid`=1.
- `o_valid`  out  1  `o_data` holds a complete result.
- `i_ready`  in  1  downstream consumes result.
- `o_busy`  out  1  high in BUSY state.

## Operation
- Define N = 16/LANES, the number of groups.
- Internal registers:
  - 128-bit state register; drives `o_data`.
  - mode bit.
  - group counter, width clog2(N) with a minimum of 1 bit.
  - 2-bit FSM.
- FSM states and transitions:
  - IDLE: `o_ready`=1. On `i_valid`=1: load state register with `i_data`, mode with `i_inverse`, counter = 0; go to BUSY.
  - BUSY: each cycle, bytes g·LANES .. g·LANES+LANES-1 (g = counter) are replaced in place by sbox(byte) or inv_sbox(byte) according to the mode bit.
    - If g = N-1: go to DONE.
    - Otherwise: counter = g+1.
    - `o_ready`=0 and `o_valid`=0 throughout.
  - DONE: `o_valid`=1; `o_data` is held stable.
    - On `i_ready`=1, the result is consumed.
    - If `i_valid`=1 in that same cycle, the new input is accepted (load, then go to BUSY).
    - Otherwise go to IDLE.
- `o_ready` = (state==IDLE) || (state==DONE && `i_ready`). It is combinational from state and `i_ready` only, and never depends on `i_valid`.
- Group order is fixed: byte 0 first, ascending.
- Bytes not yet processed keep their input value. Intermediate `o_data` during BUSY is unspecified to consumers.
- S-box contents:
  - Forward table: FIPS-197 S-box.
  - Inverse table: its exact inverse, i.e. inv_sbox(sbox(x)) = x for all 256 values.
  - Exactly LANES forward and LANES inverse lookup instances; a 2:1 byte mux per lane selects between them.
- `i_data` and `i_inverse` are ignored outside accept cycles. Changing them mid-operation has no effect.
- Reset values: FSM = IDLE, state register = 0, mode = 0, counter = 0, `o_valid`=0, `o_busy`=0.
  - `o_ready` is forced to 0 while `i_reset`=1, and is 1 on the first cycle after reset.
- Reset asserted in BUSY or DONE: the operation is discarded, no `o_valid` pulse follows, and all registers take their reset values at that edge. Reset has priority over all handshakes.

## Timing
- Accept at edge E0. BUSY occupies edges E1..EN. `o_valid` rises after edge EN, i.e. N cycles after the accept edge.
  - Latency: LANES=16 gives 1 cycle; LANES=4 gives 4; LANES=1 gives 16.
- With `i_ready` held at 1 and back-to-back `i_valid`, the result is consumed and the next input accepted in the same cycle. Throughput is one block per N cycles.
- With `i_ready`=0, `o_valid` and `o_data` hold indefinitely. `o_ready` stays 0, so no input is lost or overwritten.
- `o_valid` is registered (from state). `o_ready` has a single combinational path from `i_ready`. There is no other combinational input-to-output path.

## Test plan
- FIPS-197 forward, LANES=4, `i_ready`=1:
  - Stimulus: `i_data` = 193de3bea0f4e22b9ac68d2ae9f84808, `i_inverse`=0, `i_valid` pulse.
  - Required: `o_valid` high exactly 4 cycles after accept; `o_data` = d42711aee0bf98f1b8b45de51e415230.
- Inverse round trip, LANES=1: feed the previous output with `i_inverse`=1. Required: the original input returns after 16 cycles.
- Exhaustive table check at LANES=16 and LANES=2: byte k = (4j+k) mod 256, for j = 0..63, in both modes.
  - Required: every byte matches the golden table, e.g. 00→63, 53→ed, ff→16; inverse 63→00, 16→ff, ed→53.
  - Latency is 1 cycle at LANES=16 and 8 cycles at LANES=2.
- Backpressure:
  - Stimulus: hold `i_ready`=0 for 10 cycles after `o_valid`, with `i_valid` held at 1 and `i_data` toggling.
  - Required: `o_data` stable; `o_ready`=0; on `i_ready`=1 exactly one new accept occurs in the same cycle; `o_valid` drops for N cycles.
- Reset and mode sampling:
  - Assert `i_reset` at BUSY group 2 (LANES=4). Required: `o_valid` never rises; `o_data`=0; `o_ready`=1 the cycle after reset deasserts.
  - Toggle `i_inverse` mid-BUSY. Required: the result uses the mode sampled at accept.

Source files
------------

// File: rtl/sub_bytes_lanes_if.sv
// Valid/ready bundle around the byte-substitution engine: input state and mode in,
// substituted state out, plus a busy indicator.
interface sub_bytes_lanes_if;
  logic [0:127] i_data;
  logic         i_inverse;
  logic         i_valid;
  logic         o_ready;
  logic [0:127] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         o_busy;

  modport master (
    output i_data, i_inverse, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_busy
  );

  modport slave (
    input  i_data, i_inverse, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_busy
  );
endinterface

// File: rtl/sub_bytes_lanes.sv
// Iterative AES (Inv)SubBytes: LANES S-box lookups per cycle, result 16/LANES cycles after accept.
// A finished result holds o_valid/o_data and blocks new accepts until downstream asserts i_ready.
module sub_bytes_lanes #(
  parameter int LANES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  sub_bytes_lanes_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_lanes: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box, entry x at bits [8x:8x+7]
  localparam logic [0:2047] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [0:2047] invert_table(input logic [0:2047] fwd);
    logic [0:2047] inv;
    logic [7:0]    x;
    logic [7:0]    y;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      x = i[7:0];
      y = fwd[{x, 3'b000} +: 8];
      inv[{y, 3'b000} +: 8] = x;
    end
    return inv;
  endfunction

  // Deriving the inverse from the forward table guarantees inv_sbox(sbox(x)) == x.
  localparam logic [0:2047] SBOX_INV = invert_table(SBOX_FWD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [0:127]    data_q, data_d;
  logic            inv_q, inv_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 8'h00;
      for (int g = 0; g < N; g++) begin
        if (cnt_q == CW'(g)) lane_in[l] = data_q[8*(g*LANES+l) +: 8];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd_b;
    logic [7:0] inv_b;
    assign fwd_b       = SBOX_FWD[{lane_in[l], 3'b000} +: 8];
    assign inv_b       = SBOX_INV[{lane_in[l], 3'b000} +: 8];
    assign lane_out[l] = inv_q ? inv_b : fwd_b;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          data_d  = bus.i_data;
          inv_d   = bus.i_inverse;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < N; g++) begin
          for (int l = 0; l < LANES; l++) begin
            if (cnt_q == CW'(g)) data_d[8*(g*LANES+l) +: 8] = lane_out[l];
          end
        end
        if (cnt_q == CW'(N-1)) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          if (bus.i_valid) begin
            data_d  = bus.i_data;
            inv_d   = bus.i_inverse;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_BUSY);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_ready = !i_reset &&
                       ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.i_ready));

endmodule
